// File: rtl/spi_pkg.sv
// Shared SPI types and constants.
// Used by the SPI receiver and its synchronizer.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    DONE
  } spi_rx_state_t;

  localparam int SPI_MSB_FIRST   = 0;
  localparam int SPI_LSB_FIRST   = 1;
  localparam int SPI_DATA_LENGTH = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchronizer with a history flop.
// Provides the synced level plus rise and fall detects.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SYNC_STAGES:0]   fill_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], D};
      hist_q <= LEVEL;
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are reported only once every flop holds a real sample,
  // so the forced reset value never looks like a transition.
  assign LEVEL = sync_q[SYNC_STAGES-1];
  assign RISE  = fill_q[SYNC_STAGES] & LEVEL & ~hist_q;
  assign FALL  = fill_q[SYNC_STAGES] & ~LEVEL & hist_q;

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver, oversampled in the CLK domain.
// Delivers one word per SS_N frame over a valid/ready port.
module spi_rx
  import spi_pkg::*;
#(
  parameter int DATA_LENGTH     = SPI_DATA_LENGTH,
  parameter int SHIFT_DIRECTION = SPI_MSB_FIRST,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   MCLK,
  input  logic                   SS_N,
  input  logic                   SDI,
  output logic [DATA_LENGTH-1:0] DATA,
  output logic                   VALID,
  input  logic                   READY,
  output logic                   BUSY,
  output logic                   OVERRUN,
  output logic                   FRAME_ERR
);

  localparam int CW = $clog2(DATA_LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_LENGTH);

  logic mclk_rise, ss_rise, ss_fall, sdi_lvl;
  logic unused_mclk_lvl, unused_mclk_fall, unused_ss_lvl;
  logic unused_sdi_rise, unused_sdi_fall;

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_mclk (
    .CLK  (CLK),
    .RST_N(RST_N),
    .D    (MCLK),
    .LEVEL(unused_mclk_lvl),
    .RISE (mclk_rise),
    .FALL (unused_mclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_ss (
    .CLK  (CLK),
    .RST_N(RST_N),
    .D    (SS_N),
    .LEVEL(unused_ss_lvl),
    .RISE (ss_rise),
    .FALL (ss_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sdi (
    .CLK  (CLK),
    .RST_N(RST_N),
    .D    (SDI),
    .LEVEL(sdi_lvl),
    .RISE (unused_sdi_rise),
    .FALL (unused_sdi_fall)
  );

  spi_rx_state_t          state_q, state_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic [DATA_LENGTH-1:0] sr_q, sr_n, shifted;
  logic                   done_q, done_n, ferr_n;

  always_comb begin
    if (SHIFT_DIRECTION == SPI_LSB_FIRST)
      shifted = {sdi_lvl, sr_q[DATA_LENGTH-1:1]};
    else
      shifted = {sr_q[DATA_LENGTH-2:0], sdi_lvl};
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sr_n    = sr_q;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_n = RECEIVE;
          cnt_n   = '0;
          sr_n    = '0;
        end
      end
      RECEIVE: begin
        if (mclk_rise) begin
          sr_n  = shifted;
          cnt_n = cnt_q + CW'(1);
          if (cnt_n == LAST) begin
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
        // A final bit landing with SS_N rise still completes the word.
        if (ss_rise) begin
          ferr_n  = ~done_n;
          state_n = IDLE;
        end
      end
      DONE: begin
        if (ss_rise) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      done_q    <= 1'b0;
      DATA      <= '0;
      VALID     <= 1'b0;
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      sr_q      <= sr_n;
      done_q    <= done_n;
      FRAME_ERR <= ferr_n;
      if (done_q) begin
        DATA  <= sr_q;
        VALID <= 1'b1;
        if (VALID && !READY) OVERRUN <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state_q != IDLE);

endmodule
